spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 37 +++
 rtl/spi_slave.sv | 111 +++++++++++
 tb/tb_spi_slave.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// SPI slave pin bundle plus the byte-level side presented to the local consumer.
// The slave modport is what spi_slave sees; master is the host/consumer view.
interface spi_slave_if;
    logic       spi_sclk_i;
    logic       spi_cs_n_i;
    logic       spi_mosi_i;
    logic       spi_dc_i;
    logic [7:0] tx_byte_i;
    logic       spi_miso_o;
    logic       spi_byte_vld_o;
    logic [7:0] spi_byte_data_o;
    logic       dc_o;

    modport slave (
        input  spi_sclk_i,
        input  spi_cs_n_i,
        input  spi_mosi_i,
        input  spi_dc_i,
        input  tx_byte_i,
        output spi_miso_o,
        output spi_byte_vld_o,
        output spi_byte_data_o,
        output dc_o
    );

    modport master (
        output spi_sclk_i,
        output spi_cs_n_i,
        output spi_mosi_i,
        output spi_dc_i,
        output tx_byte_i,
        input  spi_miso_o,
        input  spi_byte_vld_o,
        input  spi_byte_data_o,
        input  dc_o
    );
endinterface

// File: rtl/spi_slave.sv
// Mode-0 SPI slave oversampled in the clk_i domain: synchronizes the SPI pins,
// assembles MSB-first bytes with a DC tag and shifts a reply byte out on MISO.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic       clk_i,
    input logic       rst_n_i,
    spi_slave_if.slave bus
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, dc_sync_q;
    logic                   sclk_dly_q, cs_dly_q;

    logic       sclk_s, cs_s, mosi_s, dc_s;
    logic       rise, fall, cs_fall;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] data_q, data_d;
    logic       dc_q, dc_d;
    logic       vld_q, vld_d;
    logic       have_byte_q, have_byte_d;

    // CS resets high so the bus looks idle until the host really selects us.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            dc_sync_q   <= '0;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi_i};
            dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], bus.spi_dc_i};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
            cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign dc_s    = dc_sync_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_dly_q & ~cs_s;
    assign fall    = ~sclk_s & sclk_dly_q & ~cs_s;
    assign cs_fall = ~cs_s & cs_dly_q;

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        data_d      = data_q;
        dc_d        = dc_q;
        vld_d       = 1'b0;
        have_byte_d = have_byte_q;
        if (cs_s) begin
            // Deselect drops any partial byte, including one completing this cycle.
            bit_cnt_d   = 3'd0;
            rx_d        = 8'h00;
            have_byte_d = 1'b0;
        end else if (cs_fall) begin
            tx_d = bus.tx_byte_i;
        end else if (rise) begin
            rx_d      = {rx_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                data_d      = {rx_q[6:0], mosi_s};
                dc_d        = dc_s;
                vld_d       = 1'b1;
                have_byte_d = 1'b1;
            end
        end else if (fall) begin
            // First fall after a completed byte fetches the next reply byte.
            if (bit_cnt_q == 3'd0 && have_byte_q) begin
                tx_d = bus.tx_byte_i;
            end else begin
                tx_d = {tx_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            data_q      <= 8'h00;
            dc_q        <= 1'b0;
            vld_q       <= 1'b0;
            have_byte_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            data_q      <= data_d;
            dc_q        <= dc_d;
            vld_q       <= vld_d;
            have_byte_q <= have_byte_d;
        end
    end

    assign bus.spi_miso_o      = tx_q[7] & ~cs_s;
    assign bus.spi_byte_vld_o  = vld_q;
    assign bus.spi_byte_data_o = data_q;
    assign bus.dc_o            = dc_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: host-side SPI bit-banging with SCLK = clk/8 and
// hand-computed expected bytes, strobe counts, latency and MISO contents.
module tb_spi_slave;

    localparam int unsigned SyncStages = 2;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;

    spi_slave_if bus ();

    spi_slave #(.SYNC_STAGES(SyncStages)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Strobe log, written only here; sampled on the falling clock edge.
    int         strobe_cnt = 0;
    logic [8:0] log_val [64];
    int         log_cyc [64];
    always @(negedge clk_i) begin
        if (bus.spi_byte_vld_o === 1'b1) begin
            if (strobe_cnt < 64) begin
                log_val[strobe_cnt] <= {bus.dc_o, bus.spi_byte_data_o};
                log_cyc[strobe_cnt] <= cyc;
            end
            strobe_cnt <= strobe_cnt + 1;
        end
    end

    // Reply byte switches to tx_alt in the strobe cycle once strobe_cnt passes tx_mark.
    logic [7:0] tx_base = 8'h00;
    logic [7:0] tx_alt  = 8'h00;
    int         tx_mark = 32'h7fff_ffff;
    assign bus.tx_byte_i = (strobe_cnt > tx_mark) ? tx_alt : tx_base;

    int checks = 0;
    int errors = 0;
    int last_rise_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic miso);
        bus.spi_sclk_i = 1'b0;
        bus.spi_mosi_i = b;
        repeat (4) @(negedge clk_i);
        miso           = bus.spi_miso_o;
        bus.spi_sclk_i = 1'b1;
        last_rise_cyc  = cyc;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] m);
        logic mb;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(b[i], mb);
            m[i] = mb;
        end
    endtask

    task automatic sclk_idle();
        bus.spi_sclk_i = 1'b0;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic cs_low();
        bus.spi_cs_n_i = 1'b0;
        repeat (6) @(negedge clk_i);
    endtask

    task automatic cs_high();
        bus.spi_sclk_i = 1'b0;
        repeat (2) @(negedge clk_i);
        bus.spi_cs_n_i = 1'b1;
        repeat (6) @(negedge clk_i);
    endtask

    initial begin
        int         base;
        logic [7:0] m1, m2;
        logic       mb, miso_or;
        logic [7:0] seq [3];
        seq[0] = 8'hA5;
        seq[1] = 8'h3C;
        seq[2] = 8'hFF;

        bus.spi_sclk_i = 1'b0;
        bus.spi_cs_n_i = 1'b1;
        bus.spi_mosi_i = 1'b0;
        bus.spi_dc_i   = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("rst_vld", {31'd0, bus.spi_byte_vld_o}, 32'd0);
        check_eq("rst_data", {24'd0, bus.spi_byte_data_o}, 32'h00);
        check_eq("rst_dc", {31'd0, bus.dc_o}, 32'd0);
        check_eq("rst_miso", {31'd0, bus.spi_miso_o}, 32'd0);
        rst_n_i = 1'b1;
        repeat (4) @(negedge clk_i);

        // Single command byte with latency check.
        base = strobe_cnt;
        bus.spi_dc_i = 1'b0;
        cs_low();
        spi_byte(8'h2c, m1);
        sclk_idle();
        cs_high();
        check_eq("b2c_count", strobe_cnt - base, 32'd1);
        check_eq("b2c_val", {23'd0, log_val[base]}, {23'd0, 1'b0, 8'h2c});
        check_eq("b2c_latency", log_cyc[base] - last_rise_cyc, SyncStages + 1);
        check_eq("b2c_held", {24'd0, bus.spi_byte_data_o}, 32'h2c);

        // Three back-to-back data bytes.
        base = strobe_cnt;
        bus.spi_dc_i = 1'b1;
        cs_low();
        for (int i = 0; i < 3; i++) spi_byte(seq[i], m1);
        sclk_idle();
        cs_high();
        check_eq("b2b_count", strobe_cnt - base, 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("b2b_val%0d", i), {23'd0, log_val[base + i]},
                     {23'd0, 1'b1, seq[i]});
        end

        // MISO: CS-fall load then post-strobe reload.
        tx_base = 8'h96;
        tx_alt  = 8'h5A;
        tx_mark = strobe_cnt;
        cs_low();
        spi_byte(8'h00, m1);
        spi_byte(8'h00, m2);
        sclk_idle();
        cs_high();
        check_eq("miso_byte0", {24'd0, m1}, 32'h96);
        check_eq("miso_byte1", {24'd0, m2}, 32'h5A);
        tx_mark = 32'h7fff_ffff;
        tx_base = 8'h00;

        // Partial byte discarded by CS deassert.
        base = strobe_cnt;
        bus.spi_dc_i = 1'b1;
        cs_low();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, mb);
        cs_high();
        cs_low();
        spi_byte(8'h81, m1);
        sclk_idle();
        cs_high();
        check_eq("part_count", strobe_cnt - base, 32'd1);
        check_eq("part_val", {23'd0, log_val[base]}, {23'd0, 1'b1, 8'h81});

        // Asynchronous reset mid-byte.
        tx_base = 8'hFF;
        bus.spi_dc_i = 1'b0;
        cs_low();
        for (int i = 0; i < 3; i++) spi_bit(1'b1, mb);
        check_eq("pre_rst_miso", {31'd0, bus.spi_miso_o}, 32'd1);
        base = strobe_cnt;
        #2 rst_n_i = 1'b0;
        #1;
        check_eq("arst_vld", {31'd0, bus.spi_byte_vld_o}, 32'd0);
        check_eq("arst_data", {24'd0, bus.spi_byte_data_o}, 32'h00);
        check_eq("arst_dc", {31'd0, bus.dc_o}, 32'd0);
        check_eq("arst_miso", {31'd0, bus.spi_miso_o}, 32'd0);
        bus.spi_sclk_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (6) @(negedge clk_i);
        for (int i = 0; i < 5; i++) spi_bit(1'b0, mb);
        cs_high();
        check_eq("arst_nostrobe", strobe_cnt - base, 32'd0);
        cs_low();
        spi_byte(8'hF0, m1);
        sclk_idle();
        cs_high();
        check_eq("arst_count", strobe_cnt - base, 32'd1);
        check_eq("arst_val", {23'd0, log_val[base]}, {23'd0, 1'b0, 8'hF0});

        // SCLK activity with CS high is ignored.
        base    = strobe_cnt;
        miso_or = 1'b0;
        for (int i = 0; i < 12; i++) begin
            spi_bit(1'b1, mb);
            miso_or = miso_or | mb | bus.spi_miso_o;
        end
        sclk_idle();
        check_eq("csh_nostrobe", strobe_cnt - base, 32'd0);
        check_eq("csh_miso", {31'd0, miso_or}, 32'd0);
        bus.spi_dc_i = 1'b1;
        cs_low();
        spi_byte(8'h5B, m1);
        sclk_idle();
        cs_high();
        check_eq("csh_count", strobe_cnt - base, 32'd1);
        check_eq("csh_val", {23'd0, log_val[base]}, {23'd0, 1'b1, 8'h5B});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
